// File: rtl/superio_pkg.sv
// Shared SuperIO types and defaults: ISA bus widths, decoder window base and
// the write-decoder state encoding.
package superio_pkg;

  localparam int ISA_ADDR_WIDTH = 10;
  localparam int ISA_DATA_WIDTH = 8;
  localparam logic [ISA_ADDR_WIDTH-1:0] DEFAULT_BASE_ADDR = 10'h220;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SETTLE       = 2'd1,
    STROBE       = 2'd2,
    WAIT_RELEASE = 2'd3
  } iowr_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a group of asynchronous inputs. RESET_VAL lets
// active-low strobes come out of reset in their inactive state.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_io_write_decoder.sv
// Turns asynchronous ISA IOW# cycles into single-cycle active-low register
// load strobes plus a held write-data bus, filtering glitches and DMA cycles.
module isa_io_write_decoder
  import superio_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = ISA_ADDR_WIDTH,
  parameter int                    DATA_WIDTH    = ISA_DATA_WIDTH,
  parameter int                    NUM_REGS      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    SETTLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  isa_iow_n,
  input  logic                  isa_aen,
  input  logic [ADDR_WIDTH-1:0] isa_sa,
  input  logic [DATA_WIDTH-1:0] isa_sd,
  output logic [NUM_REGS-1:0]   load_n,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write_hit,
  output logic [7:0]            glitch_count,
  output iowr_state_t           dbg_state
);

  localparam int                    IDX_W    = $clog2(NUM_REGS);
  localparam int                    CNT_W    = 4;
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'(NUM_REGS - 1);

  logic                  iow_s;
  logic                  aen_s;
  logic [ADDR_WIDTH-1:0] sa_s;
  logic [DATA_WIDTH-1:0] sd_s;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_iow (
    .clk(clk), .reset(reset), .d_i(isa_iow_n), .q_o(iow_s)
  );
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_aen (
    .clk(clk), .reset(reset), .d_i(isa_aen), .q_o(aen_s)
  );
  sync_2ff #(.WIDTH(ADDR_WIDTH), .RESET_VAL('0)) u_sync_sa (
    .clk(clk), .reset(reset), .d_i(isa_sa), .q_o(sa_s)
  );
  sync_2ff #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_sync_sd (
    .clk(clk), .reset(reset), .d_i(isa_sd), .q_o(sd_s)
  );

  iowr_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  iow_dly_q;
  logic [1:0]            rel_q;
  logic                  armed_q, armed_d;
  logic [NUM_REGS-1:0]   load_n_q, load_n_d;
  logic                  write_hit_q, write_hit_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            glitch_q, glitch_d;
  logic                  fall;
  logic                  win_hit;

  // The synchroniser reset value makes IOW look high for two cycles after
  // reset; only a high sample taken once the pipeline holds real pin data
  // arms edge detection, so a pin held low across reset never strobes.
  assign fall    = armed_q && !iow_s && iow_dly_q;
  assign win_hit = !aen_s && ((sa_s & ~IDX_MASK) == BASE_ADDR);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q | (rel_q[1] & iow_s);
    load_n_d    = '1;
    write_hit_d = 1'b0;
    wdata_d     = wdata_q;
    glitch_d    = glitch_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (iow_s) begin
          state_d = IDLE;
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q == '0) begin
          // Capture edge: the strobe is registered here so it is low in STROBE.
          state_d = STROBE;
          wdata_d = sd_s;
          if (win_hit) begin
            load_n_d[sa_s[IDX_W-1:0]] = 1'b0;
            write_hit_d               = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE:       state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (iow_s) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      iow_dly_q   <= 1'b1;
      rel_q       <= 2'b00;
      armed_q     <= 1'b0;
      load_n_q    <= '1;
      write_hit_q <= 1'b0;
      wdata_q     <= '0;
      glitch_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iow_dly_q   <= iow_s;
      rel_q       <= {rel_q[0], 1'b1};
      armed_q     <= armed_d;
      load_n_q    <= load_n_d;
      write_hit_q <= write_hit_d;
      wdata_q     <= wdata_d;
      glitch_q    <= glitch_d;
    end
  end

  assign load_n       = load_n_q;
  assign write_hit    = write_hit_q;
  assign wdata        = wdata_q;
  assign glitch_count = glitch_q;
  assign dbg_state    = state_q;

endmodule
